// File: rtl/ring_rr_arbiter_if.sv
// Handshake bundle between N requesters and the ring round-robin arbiter.
// Ports: req/done from requesters; grant, grant_valid, token, timeout back.
interface ring_rr_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [N-1:0] token;
    logic         timeout;

    // Arbiter side
    modport master (
        input  req,
        input  done,
        output grant,
        output grant_valid,
        output token,
        output timeout
    );

    // Requester side
    modport slave (
        output req,
        output done,
        input  grant,
        input  grant_valid,
        input  token,
        input  timeout
    );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority token and hold timeout.
// Ports: clk, rst_n (async active-low), bus (master): req/done in, grant,
// grant_valid, token, timeout out (all registered).
module ring_rr_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ring_rr_arbiter_if.master bus
);
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          grant_valid_q, grant_valid_d;
    logic [N-1:0]  token_q, token_d;
    logic          timeout_q, timeout_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick;
    logic [N-1:0] sel;
    logic         own_done;
    logic         own_req;
    logic         expired;

    // Requests at or above the token position win first; otherwise wrap
    // around and take the lowest set request. x & -x isolates lowest bit.
    always_comb begin
        hi_mask = ~(token_q - ONE);
        req_hi  = bus.req & hi_mask;
        pick    = (|req_hi) ? req_hi : bus.req;
        sel     = pick & (~pick + ONE);
    end

    assign own_done = |(bus.done & grant_q);
    assign own_req  = |(bus.req & grant_q);
    assign expired  = (hold_q == HMAX);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        token_d   = token_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (|bus.req) begin
                    state_d = BUSY;
                    grant_d = sel;
                    // Winner drops to lowest priority next round.
                    token_d = {sel[N-2:0], sel[N-1]};
                    hold_d  = HW'(1);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            BUSY: begin
                if (own_done || !own_req || expired) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    hold_d    = '0;
                    // Done and withdrawal take precedence over expiry.
                    timeout_d = !own_done && own_req;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            token_q       <= ONE;
            timeout_q     <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            token_q       <= token_d;
            timeout_q     <= timeout_d;
            hold_q        <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.token       = token_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one downstream resource (the ring-counter datapath) between N requesters. A one-hot priority token rotates around the requesters like a ring counter. The arbiter issues one registered one-hot grant at a time and reclaims it on a done handshake, on request withdrawal, or on a hold-time timeout. It sits between the requesting engines and the shared resource and is the only agent that drives its select lines.

## Interface
- N, default 3: number of requesters; N ≥ 2.
- MAX_HOLD, default 8: maximum consecutive cycles one grant is held; MAX_HOLD ≥ 2.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset_n  in  1  reset; asynchronous and active-low.
- Req  in  N  request per requester; level-sensitive, held until served.
- Done  in  N  1-cycle release pulse from the current owner; bits of non-owners are ignored.
- Grant  out  N  one-hot grant, or all-zero; registered.
- Grant_valid  out  1  OR of Grant; registered.
- Token  out  N  one-hot priority pointer; the marked requester has highest priority.
- Timeout  out  1  1-cycle pulse when a grant is revoked by hold expiry.

## Operation
- State machine: IDLE, BUSY, GAP. A hold counter of width clog2(MAX_HOLD)+1 counts cycles in BUSY.
- Reset (asynchronous, immediate): state=IDLE, Grant=0, Grant_valid=0, Token=1 (bit 0), Timeout=0, hold counter=0.
- Selection: pick the first set Req bit scanning from Token's position upward, wrapping N-1 → 0.
- IDLE or GAP, any Req set:
  - Next edge sets Grant to the selected one-hot and moves to BUSY.
  - Token rotates to the position one above the winner, wrapping N-1 → 0. The winner therefore has lowest priority next time.
  - Hold counter is loaded with 1.
- IDLE or GAP, Req=0: go to or stay in IDLE. Grant=0. Token is unchanged.
- BUSY, release conditions evaluated at each edge, in priority order:
  1. Done[owner]=1 → normal release.
  2. Req[owner]=0 → withdrawal release.
  3. hold counter = MAX_HOLD → timeout release. Timeout=1 for the following cycle.
- BUSY, no release condition: keep Grant and increment the hold counter.
- Any release: Grant=0, move to GAP. GAP always lasts exactly one cycle. Two owners are never granted in adjacent cycles.
- If Done and hold expiry coincide, Done wins and Timeout stays 0.
- Token changes only when a grant is issued.
- Timeout is 0 in every cycle except the one following a timeout release.
- Invariant: Grant is one-hot or zero, Grant_valid equals OR of Grant, and Token is always one-hot.

## Timing
- Grant latency from IDLE: Req sampled high at edge E gives Grant high in the cycle after E (1 cycle).
- Grant duration: 1 to MAX_HOLD cycles.
  - Done high in the first granted cycle gives a 1-cycle grant.
  - With no release, Grant is high for exactly MAX_HOLD cycles.
- Handover: owner release at edge E means Grant=0 in cycle E+1 (GAP) and the next grant is visible from cycle E+2.
- Sustained full load: throughput is one owner per (hold + 1) cycles.
- Requests rising during GAP are arbitrated at the GAP-ending edge, with no extra latency.
- Reset mid-grant: on Reset_n falling, Grant, Grant_valid and Timeout go to 0 and Token goes to 1 without waiting for a clock edge. After Reset_n rises, the first edge with Req set grants from bit 0 priority.

## Test plan
- Reset: assert Reset_n=0 asynchronously between edges → Grant=000, Grant_valid=0, Token=001, Timeout=0 immediately.
- Single requester: Req=010, Done pulsed in the 3rd granted cycle → Grant=010 for 3 cycles, then 000 for 1 cycle. Token=100 after the grant is issued.
- Round-robin fairness, N=3, MAX_HOLD=8: Req=111 held, Done never asserted → Grant sequence 001, 010, 100, 001.
  - Each grant lasts 8 cycles, separated by 1 zero cycle.
  - Timeout pulses once per handover.
- Done vs. timeout collision: Done[owner] asserted in the 8th granted cycle → release with Timeout=0.
- Withdrawal and ignored Done: owner drops Req mid-grant → Grant=0 on the next cycle. A Done pulse on a non-owner bit → no effect on Grant or Token.
- Token wrap and reset mid-operation: Token=100 with Req=011 → Grant=001.
  - Then pull Reset_n low during BUSY → all outputs return to reset values immediately.
  - After release, Req=110 → Grant=010.
